// File: rtl/sys_drain_if.sv
// Bus bundle for sys_drain: skewed bottom-row psums in, aligned vectors out,
// plus upstream flow-control status.
interface sys_drain_if #(
   parameter int SYS_COL    = 16,
   parameter int DATA_WIDTH = 16
);
   logic [SYS_COL-1:0]              col_vld_in;
   logic [2*SYS_COL*DATA_WIDTH-1:0] psum_in;
   logic                            out_valid;
   logic                            out_ready;
   logic [2*SYS_COL*DATA_WIDTH-1:0] out_data;
   logic                            almost_full;
   logic                            overflow;

   modport slave (
      input  col_vld_in, psum_in, out_ready,
      output out_valid, out_data, almost_full, overflow
   );

   modport master (
      output col_vld_in, psum_in, out_ready,
      input  out_valid, out_data, almost_full, overflow
   );
endinterface

// File: rtl/sys_drain.sv
// Systolic array output de-skew: one FIFO per column, a full vector is popped
// from all columns at once into a registered valid/ready output stage.
module sys_drain #(
   parameter int SYS_COL    = 16,
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 32
) (
   input logic       clk,
   input logic       rstn,
   sys_drain_if.slave bus
);
   localparam int PW = 2*DATA_WIDTH;
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL  = CW'(DEPTH);
   localparam logic [CW-1:0] AF_TH = CW'(DEPTH - SYS_COL);

   logic [PW-1:0]         mem [SYS_COL][DEPTH];
   logic [AW-1:0]         wr_ptr [SYS_COL];
   logic [AW-1:0]         rd_ptr [SYS_COL];
   logic [CW-1:0]         cnt [SYS_COL];
   logic [CW-1:0]         nxt_cnt [SYS_COL];
   logic [SYS_COL-1:0]    push;
   logic                  all_ne;
   logic                  load;
   logic                  drop;
   logic                  af_nxt;
   logic [SYS_COL*PW-1:0] head_vec;
   logic [SYS_COL*PW-1:0] out_data_r;
   logic                  out_valid_r;
   logic                  almost_full_r;
   logic                  overflow_r;

   always_comb begin
      all_ne = 1'b1;
      for (int unsigned j = 0; j < SYS_COL; j++) begin
         if (cnt[j] == '0) all_ne = 1'b0;
      end
      load = all_ne && (!out_valid_r || bus.out_ready);

      push     = '0;
      af_nxt   = 1'b0;
      head_vec = '0;
      for (int unsigned j = 0; j < SYS_COL; j++) begin
         // a full FIFO still accepts when its head leaves in the same cycle
         push[j]    = bus.col_vld_in[j] && ((cnt[j] != FULL) || load);
         nxt_cnt[j] = cnt[j] + CW'(push[j]) - CW'(load);
         if (nxt_cnt[j] >= AF_TH) af_nxt = 1'b1;
         head_vec[j*PW +: PW] = mem[j][rd_ptr[j]];
      end
      drop = |(bus.col_vld_in & ~push);
   end

   always_ff @(posedge clk) begin
      for (int unsigned j = 0; j < SYS_COL; j++) begin
         if (push[j]) mem[j][wr_ptr[j]] <= bus.psum_in[j*PW +: PW];
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int unsigned j = 0; j < SYS_COL; j++) begin
            cnt[j]    <= '0;
            wr_ptr[j] <= '0;
            rd_ptr[j] <= '0;
         end
         out_valid_r   <= 1'b0;
         out_data_r    <= '0;
         almost_full_r <= 1'b0;
         overflow_r    <= 1'b0;
      end else begin
         for (int unsigned j = 0; j < SYS_COL; j++) begin
            cnt[j] <= nxt_cnt[j];
            if (push[j]) wr_ptr[j] <= wr_ptr[j] + AW'(1);
            if (load)    rd_ptr[j] <= rd_ptr[j] + AW'(1);
         end
         if (load) begin
            out_valid_r <= 1'b1;
            out_data_r  <= head_vec;
         end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
         end
         almost_full_r <= af_nxt;
         if (drop) overflow_r <= 1'b1;
      end
   end

   assign bus.out_valid   = out_valid_r;
   assign bus.out_data    = out_data_r;
   assign bus.almost_full = almost_full_r;
   assign bus.overflow    = overflow_r;
endmodule

// File: tb/tb_sys_drain.sv
// Randomised and directed bench for sys_drain, checked every cycle against a
// queue-per-column reference model.
module tb_sys_drain;
   localparam int SC = 4;
   localparam int DW = 8;
   localparam int DP = 8;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   sys_drain_if #(.SYS_COL(SC), .DATA_WIDTH(DW)) bus ();

   sys_drain #(.SYS_COL(SC), .DATA_WIDTH(DW), .DEPTH(DP)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // reference model: one queue per column, output register
   logic [15:0] mq [SC][$];
   logic        m_valid = 1'b0;
   logic [63:0] m_data  = '0;
   logic        m_af    = 1'b0;
   logic        m_ovf   = 1'b0;
   bit          m_ne;
   bit          m_ld;
   logic [63:0] m_pop;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int j = 0; j < SC; j++) mq[j].delete();
         m_valid = 1'b0;
         m_data  = '0;
         m_af    = 1'b0;
         m_ovf   = 1'b0;
      end else begin
         m_ne = 1'b1;
         for (int j = 0; j < SC; j++) if (mq[j].size() == 0) m_ne = 1'b0;
         m_ld  = m_ne && (!m_valid || bus.out_ready);
         m_pop = '0;
         if (m_ld) for (int j = 0; j < SC; j++) m_pop[j*16 +: 16] = mq[j].pop_front();
         for (int j = 0; j < SC; j++) begin
            if (bus.col_vld_in[j]) begin
               if (mq[j].size() < DP) mq[j].push_back(bus.psum_in[j*16 +: 16]);
               else                   m_ovf = 1'b1;
            end
         end
         if (m_ld) begin
            m_valid = 1'b1;
            m_data  = m_pop;
         end else if (bus.out_ready) begin
            m_valid = 1'b0;
         end
         m_af = 1'b0;
         for (int j = 0; j < SC; j++) if (mq[j].size() >= DP - SC) m_af = 1'b1;
      end
   end

   function automatic bit model_idle();
      bit idle = !m_valid;
      for (int j = 0; j < SC; j++) if (mq[j].size() != 0) idle = 1'b0;
      return idle;
   endfunction

   // per-cycle compare, plus hold-under-backpressure property
   int          acc_cnt = 0;
   bit          af_seen = 1'b0;
   logic        p_v = 1'b0;
   logic        p_r = 1'b0;
   logic [63:0] p_d = '0;

   always @(negedge clk) begin
      chk("out_valid", 64'(bus.out_valid), 64'(m_valid));
      chk("almost_full", 64'(bus.almost_full), 64'(m_af));
      chk("overflow", 64'(bus.overflow), 64'(m_ovf));
      if (m_valid || !rstn) chk("out_data", bus.out_data, m_data);
      if (rstn && p_v && !p_r) begin
         chk("hold_valid", 64'(bus.out_valid), 64'd1);
         chk("hold_data", bus.out_data, p_d);
      end
      if (rstn && bus.out_valid && bus.out_ready) acc_cnt++;
      if (bus.almost_full) af_seen = 1'b1;
      p_v = bus.out_valid && rstn;
      p_r = bus.out_ready;
      p_d = bus.out_data;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] vecval(input logic [15:0] tag, input int k);
      logic [63:0] v;
      for (int j = 0; j < SC; j++) v[j*16 +: 16] = 16'(int'(tag) + k*16 + j);
      return v;
   endfunction

   // skewed vector stream; optional issue gating on almost_full, ready stall, literal checks
   task automatic stream(input int n, input logic [15:0] tag, input bit gate,
                         input int stall_at, input int stall_len, input bit lit);
      int st [64];
      int kn   = 0;
      int c    = 0;
      int kexp = 0;
      int gaps = 0;
      bit idle = 1'b0;
      while ((kn < n || c < st[n-1] + SC) && c < 2000) begin
         if (kn < n && (!gate || !bus.almost_full)) begin
            st[kn] = c;
            kn++;
         end
         bus.col_vld_in = '0;
         bus.psum_in    = '0;
         for (int j = 0; j < SC; j++) begin
            for (int k = 0; k < kn; k++) begin
               if (st[k] + j == c) begin
                  bus.col_vld_in[j]       = 1'b1;
                  bus.psum_in[j*16 +: 16] = 16'(int'(tag) + k*16 + j);
               end
            end
         end
         bus.out_ready = !(c >= stall_at && c < stall_at + stall_len);
         tick();
         if (lit) begin
            if (bus.out_valid) begin
               chk("stream_data", bus.out_data, vecval(tag, kexp));
               kexp++;
            end else if (kexp > 0 && kexp < n) gaps++;
         end
         c++;
      end
      bus.col_vld_in = '0;
      bus.out_ready  = 1'b1;
      for (int i = 0; i < 40 && !idle; i++) begin
         tick();
         if (lit) begin
            if (bus.out_valid) begin
               chk("stream_data", bus.out_data, vecval(tag, kexp));
               kexp++;
            end else if (kexp > 0 && kexp < n) gaps++;
         end
         idle = model_idle();
      end
      chk("stream_drained", 64'(idle), 64'd1);
      if (lit) begin
         chk("stream_count", 64'(kexp), 64'(n));
         chk("stream_gaps", 64'(gaps), 64'd0);
      end
   endtask

   initial begin
      int a0;
      int got;
      int stale;

      bus.col_vld_in = '0;
      bus.psum_in    = '0;
      bus.out_ready  = 1'b0;
      repeat (3) tick();
      chk("rst_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_data", bus.out_data, 64'd0);
      chk("rst_af", 64'(bus.almost_full), 64'd0);
      chk("rst_ovf", 64'(bus.overflow), 64'd0);
      rstn = 1'b1;
      repeat (2) tick();

      // single skewed vector
      for (int c = 0; c < 8; c++) begin
         bus.col_vld_in = '0;
         bus.psum_in    = '0;
         bus.out_ready  = 1'b1;
         if (c < SC) begin
            bus.col_vld_in[c]       = 1'b1;
            bus.psum_in[c*16 +: 16] = 16'(16'h0100 + c);
         end
         tick();
         if (c == 3) chk("single_early", 64'(bus.out_valid), 64'd0);
         if (c == 4) begin
            chk("single_valid", 64'(bus.out_valid), 64'd1);
            chk("single_data", bus.out_data, 64'h0103_0102_0101_0100);
         end
         if (c == 5) chk("single_clear", 64'(bus.out_valid), 64'd0);
      end

      // streaming, then backpressure with almost_full-gated issue
      stream(20, 16'h0000, 1'b0, 1000, 0, 1'b1);
      chk("stream_ovf", 64'(bus.overflow), 64'd0);
      a0      = acc_cnt;
      af_seen = 1'b0;
      stream(20, 16'h2000, 1'b1, 8, 6, 1'b0);
      chk("bp_count", 64'(acc_cnt - a0), 64'd20);
      chk("bp_af_seen", 64'(af_seen), 64'd1);
      chk("bp_ovf", 64'(bus.overflow), 64'd0);

      // overflow on column 0
      bus.out_ready = 1'b0;
      for (int i = 0; i < 9; i++) begin
         bus.col_vld_in     = 4'b0001;
         bus.psum_in        = '0;
         bus.psum_in[15:0]  = 16'(16'h0A00 + i);
         tick();
      end
      bus.col_vld_in = '0;
      tick();
      chk("ovf_set", 64'(bus.overflow), 64'd1);
      got = 0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 14; i++) begin
         bus.col_vld_in = (i < 8) ? 4'b1110 : 4'b0000;
         bus.psum_in    = '0;
         for (int j = 1; j < SC; j++) bus.psum_in[j*16 +: 16] = 16'(16'h0B00 + j*16 + i);
         tick();
         if (bus.out_valid) begin
            chk("ovf_order", 64'(bus.out_data[15:0]), 64'(16'h0A00 + got));
            got++;
         end
      end
      chk("ovf_count", 64'(got), 64'd8);
      chk("ovf_sticky", 64'(bus.overflow), 64'd1);

      // asynchronous reset with three entries buffered in column 0
      for (int i = 0; i < 3; i++) begin
         bus.col_vld_in    = 4'b0001;
         bus.psum_in       = '0;
         bus.psum_in[15:0] = 16'(16'h0C00 + i);
         tick();
      end
      bus.col_vld_in = '0;
      #2 rstn = 1'b0;
      #1;
      chk("arst_valid", 64'(bus.out_valid), 64'd0);
      chk("arst_data", bus.out_data, 64'd0);
      chk("arst_ovf", 64'(bus.overflow), 64'd0);
      chk("arst_af", 64'(bus.almost_full), 64'd0);
      repeat (2) tick();
      rstn = 1'b1;
      bus.col_vld_in = 4'b1110;
      bus.psum_in    = {$urandom, $urandom};
      tick();
      bus.col_vld_in = '0;
      stale = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bus.out_valid) stale++;
      end
      chk("arst_no_stale", 64'(stale), 64'd0);
      bus.col_vld_in = 4'b0001;
      bus.psum_in    = {$urandom, $urandom};
      tick();
      bus.col_vld_in = '0;
      repeat (4) tick();

      // all FIFOs full, output held, then push plus pop in the same cycle
      bus.out_ready = 1'b0;
      for (int i = 0; i < 9; i++) begin
         bus.col_vld_in = 4'b1111;
         bus.psum_in    = {$urandom, $urandom};
         tick();
      end
      bus.col_vld_in = '0;
      tick();
      chk("full_valid", 64'(bus.out_valid), 64'd1);
      chk("full_af", 64'(bus.almost_full), 64'd1);
      a0 = acc_cnt;
      bus.col_vld_in = 4'b1111;
      bus.psum_in    = {$urandom, $urandom};
      bus.out_ready  = 1'b1;
      tick();
      bus.col_vld_in = '0;
      chk("full_ovf", 64'(bus.overflow), 64'd0);
      chk("full_af_hold", 64'(bus.almost_full), 64'd1);
      repeat (15) tick();
      chk("full_drain", 64'(acc_cnt - a0), 64'd10);

      // random traffic
      for (int i = 0; i < 400; i++) begin
         bus.col_vld_in = 4'($urandom_range(15));
         bus.psum_in    = {$urandom, $urandom};
         bus.out_ready  = ($urandom_range(3) != 0);
         tick();
      end
      bus.col_vld_in = '0;
      bus.out_ready  = 1'b1;
      repeat (20) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule

// File: doc/sys_drain.md
# sys_drain

Output de-skew and drain stage for the systolic array. It captures the partial sums leaving the bottom row, where column j's result for a given input vector arrives j cycles after column 0's. It re-aligns them into one full-width output vector per input vector. Vectors are handed to the downstream buffer/writeback over a valid/ready handshake, and upstream gets an almost-full indication so it can stall issue.

## Interface
- SYS_COL, 16, number of array columns
- DATA_WIDTH, 16, operand width; each psum is 2*DATA_WIDTH bits, signed
- DEPTH, 32, entries per column FIFO; must be a power of two and ≥ 2*SYS_COL
- clk  in  1  clock, rising edge
- rstn  in  1  reset, asynchronous, active-low
- col_vld_in  in  SYS_COL  bit j: column j psum valid this cycle (bottom-row en_out, per column)
- psum_in  in  2*SYS_COL*DATA_WIDTH  bottom-row psums; column j at [2*(j+1)*DATA_WIDTH-1 : 2*j*DATA_WIDTH]
- out_valid  out  1  aligned vector available
- out_ready  in  1  downstream accepts vector
- out_data  out  2*SYS_COL*DATA_WIDTH  aligned vector, same column packing as psum_in
- almost_full  out  1  some column FIFO holds ≥ DEPTH-SYS_COL entries
- overflow  out  1  sticky: a valid psum was dropped

## Operation
- One FIFO per column, DEPTH entries of 2*DATA_WIDTH bits, with a count of log2(DEPTH)+1 bits.
- Push j: col_vld_in[j]=1 and (FIFO j not full, or pop this cycle). The slice is stored unmodified; no arithmetic, sign, or width change.
- Push j while FIFO j is full and there is no pop: the sample is dropped, overflow is set, and FIFO j is unchanged.
- all_ne: every column FIFO has count ≥ 1, using registered counts (a same-cycle push does not count).
- load = all_ne && (!out_valid || out_ready). On load, pop the head of every column FIFO simultaneously into the out_data register and set out_valid=1.
- out_valid && out_ready && !load: clear out_valid. out_data holds its value (it is don't-care once out_valid=0).
- out_valid && !out_ready: out_data and out_valid stay stable (no change until accepted).
- Push and pop on the same FIFO in the same cycle: count is unchanged, and this is legal even when full.
- Columns are independent. Ordering within a column is strict FIFO, so vector k of the output is built from the k-th sample of each column.
- almost_full is registered and computed from post-update counts.
- overflow is cleared only by rstn.

## Timing
- Reset (rstn=0, asynchronous):
  - All counts and pointers are 0.
  - out_valid=0, out_data=0, almost_full=0, overflow=0.
  - Reset mid-operation discards all buffered psums, with no partial output.
- Latency: if the last missing column sample is pushed at edge n, all_ne is true after n, load occurs at edge n+1, and out_valid=1 after edge n+1.
- Skewed stream (column j valid at cycles t+j): first out_valid after edge t+SYS_COL; steady state is one vector per cycle with out_ready=1.
- Throughput: 1 vector/cycle. Back-to-back loads with out_ready held high produce no bubbles.
- almost_full threshold leaves SYS_COL slots of headroom for the in-flight skew after upstream stalls.
- Buffered data has no timeout and waits indefinitely for the slowest column.

## Test plan
(Bench uses SYS_COL=4, DATA_WIDTH=8, DEPTH=8.)
- Reset check: assert rstn=0 mid-stream with 3 entries buffered → out_valid=0, out_data=0, overflow=0, almost_full=0 immediately; after release, no stale vector ever appears.
- Single skewed vector, out_ready=1:
  - Stimulus: column j presents 16'h0100+j at cycle 10+j.
  - Response: out_valid=1 only after edge 14, out_data={16'h0103,16'h0102,16'h0101,16'h0100}, then out_valid=0 after edge 15.
- Streaming: 20 skewed vectors, vector k column j = k*16+j, out_ready=1 → 20 consecutive out_valid cycles, values in order, no gaps, overflow=0.
- Backpressure:
  - Stimulus: hold out_ready=0 for 6 cycles during a stream.
  - Response: out_data stable while out_valid=1; almost_full=1 once any count reaches 4; no data lost after out_ready returns.
- Overflow:
  - Stimulus: with out_ready=0, push 9 samples into column 0 only.
  - Response: the 9th sample is dropped, overflow=1 and stays 1; the first 8 samples emerge in order once the other columns fill and out_ready=1.
- Full + simultaneous pop:
  - Stimulus: all FIFOs at 8 entries, out_valid=1, out_ready=1, and a push on every column in the same cycle.
  - Response: push accepted, counts remain 8, overflow stays 0.
